// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Instruction fetch front end. Keeps the fetch PC (pc_q), issues one request at
//   a time to instruction memory, and holds each returned instruction in an
//   Instr/PC register pair until decode takes it. A redirect from execute
//   (PCSrc/PCTarget) replaces pc_q. Any response that belongs to a fetch issued
//   before the redirect is thrown away, so it never reaches decode.
//
// Handshakes (all sampled on the rising edge of clk):
//   imem_req/imem_gnt     : a request issues on an edge where imem_req & imem_gnt.
//                           imem_req is high only in FETCH and depends on state alone.
//   imem_rvalid           : exactly one pulse per issued request, at least one cycle
//                           after issue. Only one request is ever outstanding.
//   instr_valid/instr_ready: a transfer happens on an edge where both are high.
//                           Instr/PC do not change while instr_valid is high and no
//                           transfer or redirect has happened.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   PCSrc, PCTarget     redirect pulse and target (PCTarget[1:0] ignored)
//   imem_req, imem_addr fetch request and byte address (pc_q truncated)
//   imem_gnt            memory accepts the request this cycle
//   imem_rvalid/rdata   returned instruction
//   instr_valid/ready   decode handshake
//   Instr, PC           held instruction and its address
//   state_dbg           current FSM state (FETCH=0, WAIT=1, VALID=2, DRAIN=3)

`timescale 1ns/1ps

module fetch_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  PCSrc,
  input  logic [DATA_WIDTH-1:0] PCTarget,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] Instr,
  output logic [DATA_WIDTH-1:0] PC,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // request on the bus, waiting for grant
    WAIT  = 2'd1,  // request issued, waiting for the wanted response
    VALID = 2'd2,  // instruction held for decode
    DRAIN = 2'd3   // request issued but redirected: swallow its response
  } state_t;

  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);
  localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(4);

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   pc_q, pc_d;
  logic [DATA_WIDTH-1:0]   target_aligned;
  logic                    capture;

  assign target_aligned = PCTarget & ALIGN_MASK;

  // Outputs are pure decodes of registered state: no path from PCSrc.
  assign imem_req    = (state_q == FETCH);
  assign instr_valid = (state_q == VALID);
  assign imem_addr   = pc_q[ADDR_WIDTH-1:0];
  assign state_dbg   = state_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    capture = 1'b0;
    case (state_q)
      FETCH: begin
        if (PCSrc) pc_d = target_aligned;
        // A grant in the redirect cycle fetched the old address: drain it.
        if (imem_gnt) state_d = PCSrc ? DRAIN : WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (PCSrc) begin
            pc_d    = target_aligned;
            state_d = FETCH;
          end else begin
            capture = 1'b1;
            state_d = VALID;
          end
        end else if (PCSrc) begin
          pc_d    = target_aligned;
          state_d = DRAIN;
        end
      end
      VALID: begin
        // Redirect wins over the sequential step even if decode took the
        // instruction in the same cycle.
        if (PCSrc) begin
          pc_d    = target_aligned;
          state_d = FETCH;
        end else if (instr_ready) begin
          pc_d    = pc_q + PC_STEP;
          state_d = FETCH;
        end
      end
      DRAIN: begin
        if (PCSrc) pc_d = target_aligned;
        if (imem_rvalid) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC & ALIGN_MASK;
      Instr   <= '0;
      PC      <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (capture) begin
        Instr <= imem_rdata;
        PC    <= pc_q;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
`timescale 1ns/1ps

module tb_fetch_sequencer;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam logic [DW-1:0] RST_PC = '0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          PCSrc = 1'b0;
  logic [DW-1:0] PCTarget = '0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt = 1'b0;
  logic          imem_rvalid = 1'b0;
  logic [DW-1:0] imem_rdata = '0;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [DW-1:0] Instr;
  logic [DW-1:0] PC;
  logic [1:0]    state_dbg;

  fetch_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .PCSrc(PCSrc), .PCTarget(PCTarget),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .Instr(Instr), .PC(PC), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard / model state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int n_xfer  = 0;

  // Architectural model: the address of the next instruction decode must see.
  logic [DW-1:0] exp_pc;
  // Optional ordered list of expected transfer PCs for directed segments.
  logic [DW-1:0] exp_q[$];

  // Memory model: one outstanding request with a countdown to its response.
  logic          out_valid;
  int            out_cnt;
  logic [AW-1:0] out_addr;

  task automatic check_eq(input string tag, input logic [63:0] obs,
                          input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Instruction memory contents; word 0 holds 0x00500093.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    logic [DW-1:0] x;
    x = DW'(a);
    return (x * 32'h0100_0193) ^ 32'h0050_0093;
  endfunction

  task automatic model_reset();
    exp_pc    = RST_PC;
    out_valid = 1'b0;
    out_cnt   = 0;
    out_addr  = '0;
    exp_q.delete();
  endtask

  // ---------------- driver: one clock cycle ----------------
  // g: grant, r: ready, p: redirect pulse, t: target, lat: extra cycles
  // before the response to a request issued on this edge (0 = next cycle).
  task automatic step(input logic g, input logic r, input logic p,
                      input logic [DW-1:0] t, input int lat);
    logic          pre_req, pre_valid, rv;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_pc, pre_instr;
    imem_gnt    = g;
    instr_ready = r;
    PCSrc       = p;
    PCTarget    = t;
    rv          = out_valid && (out_cnt == 0);
    imem_rvalid = rv;
    imem_rdata  = rv ? mem_word(out_addr) : DW'($urandom);
    pre_req   = imem_req;
    pre_addr  = imem_addr;
    pre_valid = instr_valid;
    pre_pc    = PC;
    pre_instr = Instr;
    @(posedge clk);
    #1;
    // decode sees the instruction first, then a redirect takes effect
    if (pre_valid && r) begin
      check_eq("xfer_pc", pre_pc, exp_pc);
      check_eq("xfer_instr", pre_instr, mem_word(exp_pc[AW-1:0]));
      if (exp_q.size() > 0) check_eq("xfer_order", pre_pc, exp_q.pop_front());
      exp_pc = exp_pc + 32'd4;
      n_xfer++;
    end
    if (p) exp_pc = t & ~32'd3;
    if (rv) out_valid = 1'b0;
    else if (out_valid && out_cnt > 0) out_cnt--;
    if (pre_req && g) begin
      check_eq("one_outstanding", out_valid, 1'b0);
      out_valid = 1'b1;
      out_cnt   = lat;
      out_addr  = pre_addr;
    end
    PCSrc       = 1'b0;
    imem_rvalid = 1'b0;
    if (imem_req) check_eq("fetch_addr", imem_addr, exp_pc[AW-1:0]);
    check_eq("req_xor_valid", imem_req & instr_valid, 1'b0);
    if (pre_valid && !r && !p) begin
      check_eq("hold_valid", instr_valid, 1'b1);
      check_eq("hold_pc", PC, pre_pc);
      check_eq("hold_instr", Instr, pre_instr);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int xfer0;
    logic last_p;
    logic p;
    logic [DW-1:0] held_pc, held_instr;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", instr_valid, 1'b0);
    check_eq("rst_pc", PC, RST_PC);
    check_eq("rst_instr", Instr, '0);
    check_eq("rst_state", state_dbg, 2'd0);
    rst = 1'b0;
    // first edge after release must present the reset fetch
    check_eq("rel_req", imem_req, 1'b1);
    check_eq("rel_addr", imem_addr, RST_PC[AW-1:0]);

    // First instruction: grant, response next cycle, decode ready.
    step(1, 1, 0, '0, 0);
    check_eq("wait_noreq", imem_req, 1'b0);
    step(0, 1, 0, '0, 0);
    check_eq("first_valid", instr_valid, 1'b1);
    check_eq("first_instr", Instr, 32'h0050_0093);
    check_eq("first_pc", PC, 32'h0);
    step(0, 1, 0, '0, 0);
    check_eq("next_addr", imem_addr, 12'h004);

    // Throughput: three instructions in nine cycles.
    exp_q = '{32'h4, 32'h8, 32'hC};
    xfer0 = n_xfer;
    repeat (9) step(1, 1, 0, '0, 0);
    check_eq("throughput", n_xfer - xfer0, 3);
    check_eq("order_done", exp_q.size(), 0);

    // Decode stall for five cycles in VALID.
    step(1, 0, 0, '0, 0);
    step(0, 0, 0, '0, 0);
    held_pc    = PC;
    held_instr = Instr;
    check_eq("stall_pc_val", held_pc, 32'h10);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, '0, 0);
      check_eq("stall_noreq", imem_req, 1'b0);
    end
    check_eq("stall_instr", Instr, mem_word(12'h010));
    step(0, 1, 0, '0, 0);
    check_eq("after_stall", imem_addr, 12'h014);

    // Redirect in WAIT, stale response three cycles after issue.
    step(1, 1, 0, '0, 2);
    step(0, 1, 1, 32'h0000_0103, 0);
    for (int i = 0; i < 2; i++) begin
      check_eq("drain_novalid", instr_valid, 1'b0);
      step(0, 1, 0, '0, 0);
    end
    check_eq("drain_exit_novalid", instr_valid, 1'b0);
    check_eq("redir_addr", imem_addr, 12'h100);
    check_eq("redir_req", imem_req, 1'b1);

    // Redirect in the same cycle as the response.
    step(1, 1, 0, '0, 0);
    step(0, 1, 1, 32'h40, 0);
    check_eq("same_cyc_novalid", instr_valid, 1'b0);
    check_eq("same_cyc_req", imem_req, 1'b1);
    check_eq("same_cyc_addr", imem_addr, 12'h040);

    // Wrap of pc_q and of the truncated address.
    step(0, 1, 1, 32'hFFFF_FFFC, 0);
    check_eq("wrap_addr_hi", imem_addr, 12'hFFC);
    step(1, 1, 0, '0, 0);
    step(0, 1, 0, '0, 0);
    check_eq("wrap_pc_hi", PC, 32'hFFFF_FFFC);
    step(0, 1, 0, '0, 0);
    check_eq("wrap_addr_lo", imem_addr, 12'h000);
    step(1, 1, 0, '0, 0);
    step(0, 1, 0, '0, 0);
    check_eq("wrap_pc_lo", PC, 32'h0);
    step(0, 1, 0, '0, 0);
    step(1, 1, 0, '0, 0);
    step(0, 1, 0, '0, 0);
    step(0, 1, 0, '0, 0);

    // Asynchronous reset while draining.
    step(1, 1, 1, 32'h200, 3);
    check_eq("drain_req", imem_req, 1'b0);
    check_eq("drain_valid", instr_valid, 1'b0);
    check_eq("pre_rst_pc", PC, 32'h4);
    #3;
    rst = 1'b1;
    #1;
    check_eq("arst_valid", instr_valid, 1'b0);
    check_eq("arst_pc", PC, RST_PC);
    check_eq("arst_instr", Instr, '0);
    check_eq("arst_req", imem_req, 1'b1);
    check_eq("arst_addr", imem_addr, RST_PC[AW-1:0]);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Randomized traffic against the architectural model.
    last_p = 1'b0;
    xfer0  = n_xfer;
    for (int c = 0; c < 4000; c++) begin
      p = !last_p && ($urandom_range(0, 99) < 8);
      step(($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 60), p,
           DW'($urandom), int'($urandom_range(0, 3)));
      last_p = p;
    end
    check_eq("random_progress", (n_xfer - xfer0) > 100, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, instruction/PC width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, instruction-memory byte-address width.
REQ-003 SHALL have parameter RESET_PC, default 0, first fetch address.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 PCSrc  in  1  redirect request from execute, one-cycle pulse.
REQ-007 PCTarget  in  DATA_WIDTH  redirect address, sampled when PCSrc=1.
REQ-008 imem_req  out  1  fetch request to instruction memory.
REQ-009 imem_addr  out  ADDR_WIDTH  fetch byte address, equals pc_q[ADDR_WIDTH-1:0].
REQ-010 imem_gnt  in  1  memory accepts request this cycle (req & gnt = issue).
REQ-011 imem_rvalid  in  1  read data valid, one cycle, exactly once per issued request, earliest one cycle after issue.
REQ-012 imem_rdata  in  DATA_WIDTH  returned instruction.
REQ-013 instr_valid  out  1  Instr/PC hold a valid fetched instruction.
REQ-014 instr_ready  in  1  decode accepts; transfer when instr_valid & instr_ready.
REQ-015 Instr  out  DATA_WIDTH  registered fetched instruction.
REQ-016 PC  out  DATA_WIDTH  registered address of Instr.

Function
REQ-017 SHALL keep internal register pc_q; bits [1:0] always 0 (PCTarget[1:0] ignored).
REQ-018 SHALL implement FSM states FETCH, WAIT, VALID, DRAIN; at most one request outstanding.
REQ-019 FETCH: imem_req=1; gnt & ~PCSrc -> WAIT; gnt & PCSrc -> DRAIN, pc_q<=PCTarget; ~gnt & PCSrc -> stay FETCH, pc_q<=PCTarget; ~gnt & ~PCSrc -> stay.
REQ-020 WAIT: imem_req=0; rvalid & ~PCSrc -> Instr<=imem_rdata, PC<=pc_q, -> VALID; rvalid & PCSrc -> data discarded, pc_q<=PCTarget, -> FETCH; ~rvalid & PCSrc -> pc_q<=PCTarget, -> DRAIN.
REQ-021 VALID: instr_valid=1, Instr/PC stable until transfer; transfer & ~PCSrc -> pc_q<=pc_q+4, -> FETCH; PCSrc (with or without transfer) -> pc_q<=PCTarget, -> FETCH; otherwise hold.
REQ-022 DRAIN: imem_req=0, instr_valid=0; rvalid -> data discarded, -> FETCH; PCSrc -> pc_q<=PCTarget (latest redirect wins), rvalid same cycle still exits to FETCH.
REQ-023 instr_valid SHALL be 1 only in VALID; imem_req SHALL be 1 only in FETCH; both registered-state decodes, no combinational path from PCSrc.
REQ-024 pc_q+4 SHALL wrap modulo 2^DATA_WIDTH; imem_addr truncation wraps modulo 2^ADDR_WIDTH.
REQ-025 Minimum throughput: one instruction per 3 cycles with gnt=1, rvalid one cycle after issue, instr_ready=1.
REQ-026 No instruction from a pre-redirect fetch SHALL ever reach instr_valid=1.

Reset
REQ-027 rst=1 SHALL asynchronously force state FETCH, pc_q=RESET_PC, instr_valid=0, Instr=0, PC=RESET_PC.
REQ-028 First rising edge after rst deasserts SHALL see imem_req=1, imem_addr=RESET_PC[ADDR_WIDTH-1:0].
REQ-029 Reset mid-request SHALL abandon the outstanding response; the memory model is reset alongside.

Verification
REQ-030 Reset release, gnt=1, rvalid 1 cycle after issue, rdata=0x00500093, ready=1 -> instr_valid with Instr=0x00500093, PC=0x0; next imem_addr=0x004.
REQ-031 instr_ready=0 for 5 cycles in VALID -> Instr/PC unchanged, imem_req=0 throughout, advances to PC+4 after ready.
REQ-032 PCSrc=1, PCTarget=0x0000_0103 in WAIT, rvalid 3 cycles later -> returned data never valid, next imem_addr=0x100.
REQ-033 PCSrc=1, PCTarget=0x40 same cycle as rvalid in WAIT -> no instr_valid, next state FETCH with imem_addr=0x040.
REQ-034 pc_q=0xFFFF_FFFC, transfer -> pc_q=0x0000_0000; pc_q=0xFFC with ADDR_WIDTH 12 -> imem_addr 0xFFC then 0x000.
REQ-035 rst asserted in DRAIN -> instr_valid=0, PC=RESET_PC immediately, without clock edge.
